// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states, strobe width.
package load_store_unit_pkg;

    localparam logic [2:0] Funct3Byte  = 3'b000;
    localparam logic [2:0] Funct3Half  = 3'b001;
    localparam logic [2:0] Funct3Word  = 3'b010;
    localparam logic [2:0] Funct3ByteU = 3'b100;
    localparam logic [2:0] Funct3HalfU = 3'b101;

    localparam int unsigned StrbWidth = 4;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} lsu_state_e;

    typedef enum logic [1:0] {SzByte, SzHalf, SzWord} lsu_size_e;

    // Undefined encodings fall through to a word access.
    function automatic lsu_size_e f3_size(input logic [2:0] funct3);
        case (funct3)
            Funct3Byte, Funct3ByteU: return SzByte;
            Funct3Half, Funct3HalfU: return SzHalf;
            default:                 return SzWord;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-aligned memory bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if;
    import load_store_unit_pkg::*;

    logic                 bus_valid;
    logic                 bus_ready;
    logic                 bus_we;
    logic [31:0]          bus_addr;
    logic [StrbWidth-1:0] bus_wstrb;
    logic [31:0]          bus_wdata;
    logic [31:0]          bus_rdata;

    modport master (
        output bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
        output bus_ready, bus_rdata
    );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store data/strobe placement and load lane extract + extension.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]           funct3,
    input  logic [1:0]           offset,
    input  logic [31:0]          wdata,
    input  logic [31:0]          rdata,
    output logic [31:0]          wdata_lane,
    output logic [StrbWidth-1:0] wstrb,
    output logic [31:0]          rdata_ext
);

    lsu_size_e  size;
    logic [1:0] lane;
    logic       sext;
    logic [7:0] rbyte;
    logic [15:0] rhalf;

    assign size = f3_size(funct3);
    assign sext = ~funct3[2];

    always_comb begin
        lane       = 2'b00;
        wdata_lane = wdata;
        wstrb      = 4'b1111;
        rdata_ext  = rdata;
        rbyte      = 8'h00;
        rhalf      = 16'h0000;
        unique case (size)
            SzByte: begin
                lane       = offset;
                wdata_lane = {4{wdata[7:0]}};
                wstrb      = 4'b0001 << lane;
                rbyte      = rdata[{lane, 3'b000} +: 8];
                rdata_ext  = {{24{sext & rbyte[7]}}, rbyte};
            end
            // Low address bit is dropped, so halves always sit on a half boundary.
            SzHalf: begin
                lane       = {offset[1], 1'b0};
                wdata_lane = {2{wdata[15:0]}};
                wstrb      = 4'b0011 << lane;
                rhalf      = rdata[{lane, 3'b000} +: 16];
                rdata_ext  = {{16{sext & rhalf[15]}}, rhalf};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit bridging a stalling core to a valid/ready memory bus.
// Optional misalignment trap enabled by defining LSU_MISALIGN_CHECK_EN.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       ALUResult,
    input  logic [31:0]       WriteData,
    output logic              stall,
    output logic [31:0]       ReadData,
    output logic              done,
    output logic              fault,
    load_store_unit_if.master bus
);

    lsu_state_e           state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [31:0]          addr_q, addr_d;
    logic [2:0]           funct3_q, funct3_d;
    logic                 we_q, we_d;
    logic [StrbWidth-1:0] wstrb_q, wstrb_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 fault_q, fault_d;

    logic                 misalign;
    logic                 accept;
    logic                 idle;
    logic [31:0]          lane_wdata;
    logic [StrbWidth-1:0] lane_wstrb;
    logic [31:0]          lane_rdata;

`ifdef LSU_MISALIGN_CHECK_EN
    always_comb begin
        misalign = 1'b0;
        unique case (f3_size(req_funct3))
            SzHalf:  misalign = ALUResult[0];
            SzWord:  misalign = |ALUResult[1:0];
            default: misalign = 1'b0;
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    assign idle   = (state_q == StIdle);
    assign accept = idle && req_valid && !misalign;

    // One aligner serves both paths: request fields while idle, latched fields while busy.
    lsu_lane_align u_align (
        .funct3     (idle ? req_funct3 : funct3_q),
        .offset     (idle ? ALUResult[1:0] : addr_q[1:0]),
        .wdata      (WriteData),
        .rdata      (bus.bus_rdata),
        .wdata_lane (lane_wdata),
        .wstrb      (lane_wstrb),
        .rdata_ext  (lane_rdata)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        we_d     = we_q;
        wstrb_d  = wstrb_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        fault_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d  = StBusy;
                    cnt_d    = 8'd0;
                    addr_d   = ALUResult;
                    funct3_d = req_funct3;
                    we_d     = req_write;
                    wstrb_d  = req_write ? lane_wstrb : '0;
                    wdata_d  = lane_wdata;
                end
            end
            StBusy: begin
                if (bus.bus_ready) begin
                    state_d = StDone;
                    if (!we_q) rdata_d = lane_rdata;
                end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    state_d = StDone;
                    fault_d = 1'b1;
                    rdata_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= 8'd0;
            addr_q   <= 32'h0;
            funct3_q <= 3'b000;
            we_q     <= 1'b0;
            wstrb_q  <= '0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            we_q     <= we_d;
            wstrb_q  <= wstrb_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
        end
    end

    assign bus.bus_valid = (state_q == StBusy);
    assign bus.bus_addr  = {addr_q[31:2], 2'b00};
    assign bus.bus_we    = we_q;
    assign bus.bus_wstrb = wstrb_q;
    assign bus.bus_wdata = wdata_q;

    assign stall    = accept || (state_q == StBusy);
    assign done     = (state_q == StDone);
    assign fault    = fault_q || (idle && req_valid && misalign);
    assign ReadData = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized accesses vs. a byte-level model.
module tb_load_store_unit;
    localparam int unsigned Timeout = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic        stall;
    logic [31:0] ReadData;
    logic        done;
    logic        fault;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] rd_model = 32'h0;

    load_store_unit_if bus_if ();

    load_store_unit #(.TIMEOUT_CYCLES(Timeout)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .ALUResult  (ALUResult),
        .WriteData  (WriteData),
        .stall      (stall),
        .ReadData   (ReadData),
        .done       (done),
        .fault      (fault),
        .bus        (bus_if)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference model: access width in bytes, aligned down within the word.
    function automatic int sz_bytes(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic int m_off(input logic [2:0] f3, input logic [31:0] addr);
        int n = sz_bytes(f3);
        return (int'(addr % 4) / n) * n;
    endfunction

    function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] addr);
        int n = sz_bytes(f3);
        return 4'(((1 << n) - 1) << m_off(f3, addr));
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
        int n = sz_bytes(f3);
        logic [63:0] v = 64'(rdata) >> (8 * m_off(f3, addr));
        logic [63:0] mask = (64'd1 << (8 * n)) - 64'd1;
        v = v & mask;
        if (n < 4 && f3[2] == 1'b0 && v[8 * n - 1]) v = v | ~mask;
        return v[31:0];
    endfunction

    task automatic run_access(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rd, input int delay,
                              input string name);
        logic [3:0]  estrb = wr ? m_strb(f3, addr) : 4'b0000;
        logic [31:0] ewd = 32'h0;
        logic [31:0] mask = 32'h0;
        int          off = m_off(f3, addr);
        for (int i = 0; i < 4; i++) begin
            if (estrb[i]) begin
                ewd[8 * i +: 8]  = wd[8 * (i - off) +: 8];
                mask[8 * i +: 8] = 8'hFF;
            end
        end
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; ALUResult = addr; WriteData = wd;
        #1;
        tests++;
        if (stall !== 1'b1) begin
            fails++; $display("FAIL %s req_stall: got %b want 1", name, stall);
        end
        tick;
        req_valid = 1'b0; req_write = 1'b0; ALUResult = $urandom; WriteData = $urandom;
        tests++;
        if ({bus_if.bus_valid, bus_if.bus_we, bus_if.bus_wstrb, bus_if.bus_addr} !==
            {1'b1, wr, estrb, addr[31:2], 2'b00}) begin
            fails++;
            $display("FAIL %s bus_req: got v%b we%b s%b a%h want v1 we%b s%b a%h", name,
                     bus_if.bus_valid, bus_if.bus_we, bus_if.bus_wstrb, bus_if.bus_addr,
                     wr, estrb, {addr[31:2], 2'b00});
        end
        if (wr) begin
            tests++;
            if ((bus_if.bus_wdata & mask) !== ewd) begin
                fails++;
                $display("FAIL %s wdata: got %h want %h (mask %h)", name,
                         bus_if.bus_wdata & mask, ewd, mask);
            end
        end
        for (int k = 0; k < delay; k++) begin
            bus_if.bus_ready = 1'b0;
            tick;
            tests++;
            if ({bus_if.bus_valid, done, stall} !== 3'b101) begin
                fails++;
                $display("FAIL %s wait%0d: got v%b d%b st%b want v1 d0 st1", name, k,
                         bus_if.bus_valid, done, stall);
            end
        end
        bus_if.bus_ready = 1'b1;
        bus_if.bus_rdata = rd;
        tick;
        bus_if.bus_ready = 1'b0;
        bus_if.bus_rdata = $urandom;
        if (!wr) rd_model = m_load(f3, addr, rd);
        tests++;
        if ({done, fault, stall, bus_if.bus_valid} !== 4'b1000) begin
            fails++;
            $display("FAIL %s done_cycle: got d%b f%b st%b v%b want d1 f0 st0 v0", name,
                     done, fault, stall, bus_if.bus_valid);
        end
        tests++;
        if (ReadData !== rd_model) begin
            fails++; $display("FAIL %s ReadData: got %h want %h", name, ReadData, rd_model);
        end
        tick;
        tests++;
        if ({done, stall} !== 2'b00) begin
            fails++; $display("FAIL %s done_pulse: got d%b st%b want 00", name, done, stall);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
        ALUResult = 32'h0; WriteData = 32'h0;
        bus_if.bus_ready = 1'b0; bus_if.bus_rdata = 32'h0;
        tick; tick;
        tests++;
        if ({stall, done, fault, bus_if.bus_valid, bus_if.bus_we, bus_if.bus_wstrb} !== 9'h0) begin
            fails++;
            $display("FAIL reset_ctrl: got st%b d%b f%b v%b we%b s%b want all 0", stall, done,
                     fault, bus_if.bus_valid, bus_if.bus_we, bus_if.bus_wstrb);
        end
        tests++;
        if ({bus_if.bus_addr, bus_if.bus_wdata, ReadData} !== 96'h0) begin
            fails++;
            $display("FAIL reset_data: got a%h w%h r%h want 0", bus_if.bus_addr,
                     bus_if.bus_wdata, ReadData);
        end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_directed;
        run_access(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0, "sw_100");
        run_access(1'b0, 3'b000, 32'h0000_0203, 32'h0, 32'h8000_0000, 1, "lb_203");
        run_access(1'b0, 3'b100, 32'h0000_0203, 32'h0, 32'h8000_0000, 2, "lbu_203");
        run_access(1'b1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 32'h0, 0, "sh_102");
        run_access(1'b0, 3'b101, 32'h0000_0302, 32'h0, 32'hF00D_1234, 0, "lhu_302");
        run_access(1'b0, 3'b111, 32'h0000_0404, 32'h0, 32'h8765_4321, 3, "f3_111_word");
    endtask

    task automatic test_timeout;
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; ALUResult = 32'h100;
        tick;
        req_valid = 1'b0;
        for (int k = 0; k < int'(Timeout); k++) begin
            tests++;
            if ({bus_if.bus_valid, fault, done} !== 3'b100) begin
                fails++;
                $display("FAIL timeout_busy%0d: got v%b f%b d%b want v1 f0 d0", k,
                         bus_if.bus_valid, fault, done);
            end
            tick;
        end
        rd_model = 32'h0;
        tests++;
        if ({fault, done, stall, bus_if.bus_valid, ReadData} !== {4'b1100, rd_model}) begin
            fails++;
            $display("FAIL timeout_fault: got f%b d%b st%b v%b r%h want f1 d1 st0 v0 r0",
                     fault, done, stall, bus_if.bus_valid, ReadData);
        end
        tick;
        tests++;
        if ({fault, done} !== 2'b00) begin
            fails++; $display("FAIL timeout_pulse: got f%b d%b want 00", fault, done);
        end
    endtask

    task automatic test_reset_busy;
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
        ALUResult = 32'h104; WriteData = 32'h1234_5678;
        tick;
        req_valid = 1'b0;
        tick; tick;
        reset = 1'b1;
        tick;
        rd_model = 32'h0;
        tests++;
        if ({stall, done, fault, bus_if.bus_valid, bus_if.bus_we, bus_if.bus_wstrb,
             bus_if.bus_addr, bus_if.bus_wdata, ReadData} !== 105'h0) begin
            fails++;
            $display("FAIL reset_busy: got st%b d%b f%b v%b we%b s%b a%h w%h r%h want all 0",
                     stall, done, fault, bus_if.bus_valid, bus_if.bus_we, bus_if.bus_wstrb,
                     bus_if.bus_addr, bus_if.bus_wdata, ReadData);
        end
        reset = 1'b0;
        tick;
        tests++;
        if ({done, fault, bus_if.bus_valid} !== 3'b000) begin
            fails++;
            $display("FAIL reset_busy_after: got d%b f%b v%b want 000", done, fault,
                     bus_if.bus_valid);
        end
    endtask

    task automatic test_done_ignores_req;
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b100; ALUResult = 32'h201;
        tick;
        req_valid = 1'b0;
        bus_if.bus_ready = 1'b1; bus_if.bus_rdata = 32'h0000_AB00;
        tick;
        bus_if.bus_ready = 1'b0;
        rd_model = 32'h0000_00AB;
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010; ALUResult = 32'h500;
        #1;
        tests++;
        if ({done, stall, ReadData} !== {2'b10, rd_model}) begin
            fails++;
            $display("FAIL done_req: got d%b st%b r%h want d1 st0 r%h", done, stall, ReadData,
                     rd_model);
        end
        tick;
        req_valid = 1'b0;
        tests++;
        if ({bus_if.bus_valid, done} !== 2'b00) begin
            fails++;
            $display("FAIL done_req_idle: got v%b d%b want 00", bus_if.bus_valid, done);
        end
        tick;
        tests++;
        if (bus_if.bus_valid !== 1'b0) begin
            fails++; $display("FAIL done_req_no_access: got v%b want 0", bus_if.bus_valid);
        end
    endtask

`ifdef LSU_MISALIGN_CHECK_EN
    task automatic test_misalign;
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; ALUResult = 32'h101;
        #1;
        tests++;
        if ({fault, stall} !== 2'b10) begin
            fails++; $display("FAIL misalign_req: got f%b st%b want f1 st0", fault, stall);
        end
        tick;
        req_valid = 1'b0;
        #1;
        tests++;
        if ({bus_if.bus_valid, fault, done} !== 3'b000) begin
            fails++;
            $display("FAIL misalign_after: got v%b f%b d%b want 000", bus_if.bus_valid, fault,
                     done);
        end
        tick;
    endtask
`endif

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f3   = 3'($urandom_range(0, 7));
            logic [31:0] addr = $urandom;
            logic        wr   = 1'($urandom_range(0, 1));
`ifdef LSU_MISALIGN_CHECK_EN
            addr = addr & ~32'(sz_bytes(f3) - 1);
`endif
            run_access(wr, f3, addr, $urandom, $urandom, int'($urandom_range(0, 4)),
                       $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_timeout;
        test_done_ignores_req;
        test_reset_busy;
`ifdef LSU_MISALIGN_CHECK_EN
        test_misalign;
`endif
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: max BUSY cycles waiting for bus_ready, range 1..255.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  core requests a load or store this cycle.
REQ-005 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-006 SHALL have port req_funct3  input  3  size/sign: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu.
REQ-007 SHALL have port ALUResult  input  32  byte address from the ALU.
REQ-008 SHALL have port WriteData  input  32  store data, right-aligned.
REQ-009 SHALL have port stall  output  1  freezes PC and pipeline-free core while access is in flight.
REQ-010 SHALL have port ReadData  output  32  sign-/zero-extended load result.
REQ-011 SHALL have port done  output  1  one-cycle pulse at access completion.
REQ-012 SHALL have port fault  output  1  one-cycle pulse on timeout (or misalignment, see Configuration).
REQ-013 SHALL have ports bus_valid out 1, bus_ready in 1, bus_we out 1, bus_addr out 32 (word-aligned), bus_wstrb out 4, bus_wdata out 32, bus_rdata in 32 (valid when bus_valid && bus_ready).

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-015 IDLE: on req_valid, SHALL latch address, funct3, write flag and lane-shifted data, enter BUSY next cycle.
REQ-016 stall SHALL equal (IDLE && req_valid) || BUSY; deasserted in DONE.
REQ-017 BUSY: bus_valid=1; bus_addr={addr[31:2],2'b00}; bus_we, bus_wstrb, bus_wdata SHALL stay stable until handshake.
REQ-018 Strobes: byte -> 1<<addr[1:0]; half -> 4'b0011<<{addr[1],1'b0}; word -> 4'b1111; loads drive bus_wstrb=0.
REQ-019 Store data SHALL be replicated/shifted into the addressed lane (byte at addr[1:0]*8, half at addr[1]*16).
REQ-020 On bus_valid && bus_ready SHALL capture selected lane of bus_rdata, extend per funct3, enter DONE; minimum latency request-to-done = 2 cycles.
REQ-021 BUSY cycle counter SHALL reset on entry; when it reaches TIMEOUT_CYCLES without ready, SHALL drop bus_valid, pulse fault, set ReadData=0, enter DONE.
REQ-022 DONE: done=1 for exactly one cycle, then IDLE; req_valid in DONE SHALL be ignored (core advances that cycle).
REQ-023 ReadData SHALL hold its last value until the next completed load; stores SHALL not modify it.
REQ-024 Undefined funct3 (011, 110, 111) SHALL be treated as word access.

Reset
REQ-025 reset SHALL force IDLE, counter 0, and outputs stall=0, done=0, fault=0, bus_valid=0, bus_we=0, bus_wstrb=0, bus_addr=0, bus_wdata=0, ReadData=0.
REQ-026 reset asserted in BUSY SHALL abandon the transaction with bus_valid=0 next cycle, no done/fault pulse.

Configuration
REQ-027 Macro LSU_MISALIGN_CHECK_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL pulse fault in the request cycle, issue no bus transaction, keep stall=0, stay IDLE.
REQ-028 Macro undefined: low address bits below access size SHALL be ignored (forced aligned), no misalignment fault.

Structure
REQ-029 Shared package SHALL hold funct3 size encodings, FSM state typedef, and strobe-width constant.
REQ-030 Lane select/extend logic SHALL be a sub-module lsu_lane_align (combinational, shared by store-shift and load-extract paths).

Verification
REQ-031 sw addr 0x100, data 0xDEADBEEF, ready after 1 cycle -> bus_addr 0x100, wstrb 1111, wdata 0xDEADBEEF, done in cycle 3.
REQ-032 lb addr 0x203, bus_rdata 0x80000000 -> ReadData 0xFFFFFF80; lbu same -> 0x00000080.
REQ-033 sh addr 0x102, data 0x0000ABCD -> wstrb 1100, wdata[31:16]=0xABCD.
REQ-034 lw, bus_ready never -> fault pulse after 16 BUSY cycles, ReadData 0, stall released in DONE.
REQ-035 reset asserted in 3rd BUSY cycle -> next cycle all outputs at reset values, no done.
REQ-036 With LSU_MISALIGN_CHECK_EN, lw addr 0x101 -> fault pulse same cycle, bus_valid stays 0.
